ahb_lite_sram_slave: RTL

- AHB-Lite responder (slave) backed by a byte-addressable on-chip SRAM.
- Pairs with the master-side driver clocking block: it answers transfers the bench drives, producing HREADYOUT/HRESP/HRDATA.
- Adds a programmable wait-state insertion and the two-cycle ERROR response for illegal accesses.
- Used as the reference slave in bench loopback and as a memory target in SoC-level sims.

---
 rtl/ahb_lite_sram_slave_pkg.sv | 28 ++
 rtl/ahb_lite_sram_slave_if.sv | 24 ++
 rtl/ahb_lite_sram_slave_array.sv | 27 ++
 rtl/ahb_lite_sram_slave.sv | 117 +++++++++++
 4 files changed

// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite types and constants for the SRAM responder and its bench.
package AHBpkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'b000,
    SIZE_HALF = 3'b001,
    SIZE_WORD = 3'b010
  } hsize_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or bench driver) and the SRAM responder.
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HREADY, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HREADY, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_sram_slave_array.sv
// Word-organised SRAM: byte-enabled synchronous write, combinational read.
module ahb_sram_array #(
  parameter int MEM_DEPTH = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_DEPTH];

  // Byte-lane write on the closing edge of a write data phase.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR.
module ahb_lite_sram_slave
  import AHBpkg::*;
#(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int          AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd4;

  slave_state_t  state_p1, state_nxt;
  logic [3:0]    wcnt_p1, wcnt_nxt;
  logic [AW+1:0] addr_p1;
  logic          write_p1;
  hsize_t        size_p1;
  htrans_t       trans;
  logic          accept, take, addr_err, hreadyout, we;
  logic [3:0]    be;
  logic [31:0]   mem_rdata;
  logic          unused_bits;

  // Out-of-range, oversized or misaligned transfers get the ERROR response.
  function automatic logic access_error(input logic [31:0] a, input logic [2:0] s);
    logic bad_range, bad_size, misaligned;
    bad_range  = {1'b0, a} >= ADDR_LIMIT;
    bad_size   = s > SIZE_WORD;
    misaligned = ((s == SIZE_HALF) && a[0]) || ((s == SIZE_WORD) && (a[1:0] != 2'b00));
    return bad_range | bad_size | misaligned;
  endfunction

  // Little-endian byte lanes touched by a transfer of the given size.
  function automatic logic [3:0] byte_en(input hsize_t s, input logic [1:0] a);
    case (s)
      SIZE_BYTE: return 4'b0001 << a;
      SIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  assign trans       = htrans_t'(bus.HTRANS);
  assign accept      = bus.HSEL & bus.HREADY & ((trans == TRANS_NONSEQ) | (trans == TRANS_SEQ));
  assign take        = accept & hreadyout;
  assign addr_err    = access_error(bus.HADDR, bus.HSIZE);
  assign unused_bits = ^bus.HBURST;

  // Next-state and wait-counter decision.
  always_comb begin
    state_nxt = state_p1;
    wcnt_nxt  = wcnt_p1;
    unique case (state_p1)
      ST_WAIT: begin
        if (wcnt_p1 == 4'd0) state_nxt = ST_DATA;
        else                 wcnt_nxt  = wcnt_p1 - 4'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            wcnt_nxt  = 4'(WAIT_STATES - 1);
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_p1 <= ST_IDLE;
      wcnt_p1  <= 4'd0;
    end else begin
      state_p1 <= state_nxt;
      wcnt_p1  <= wcnt_nxt;
    end
  end

  // address phase -> data phase: capture the accepted transfer attributes.
  always_ff @(posedge HCLK) begin
    if (take) begin
      addr_p1  <= bus.HADDR[AW+1:0];
      write_p1 <= bus.HWRITE;
      size_p1  <= hsize_t'(bus.HSIZE);
    end
  end

  assign be = byte_en(size_p1, addr_p1[1:0]);
  assign we = (state_p1 == ST_DATA) & write_p1 & ~HRESET;

  ahb_sram_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .AW       (AW)
  ) u_array (
    .clk  (HCLK),
    .we   (we),
    .be   (be),
    .addr (addr_p1[AW+1:2]),
    .wdata(bus.HWDATA),
    .rdata(mem_rdata)
  );

  assign hreadyout     = ~((state_p1 == ST_WAIT) | (state_p1 == ST_ERR1));
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = ((state_p1 == ST_ERR1) | (state_p1 == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign bus.HRDATA    = ((state_p1 == ST_DATA) & ~write_p1) ? mem_rdata : 32'h0;

endmodule
